// File: rtl/photonic_stream_layer_if.sv
// Stream bundle between photonic layers: sample in, result plus
// per-channel saturation flags out, each side with valid/ready.
interface photonic_stream_layer_if #(
    parameter int N_CH      = 4,
    parameter int PRECISION = 8
);
    logic [N_CH*PRECISION-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_CH*PRECISION-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_CH-1:0]           out_sat;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_sat
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_sat
    );
endinterface

// File: rtl/photonic_stream_layer.sv
// Three-stage per-channel weight/bias/ReLU layer with saturation
// and full valid/ready backpressure (capture, multiply, add/activate).
module photonic_stream_layer #(
    parameter int N_CH      = 4,
    parameter int PRECISION = 8,
    parameter int FRAC      = 4,
    parameter int CFG_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    photonic_stream_layer_if.slave io,
    input  logic [1:0]           mode,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [CFG_AW-1:0]    cfg_addr,
    input  logic [PRECISION-1:0] cfg_wdata,
    output logic                 cfg_ready
);
    localparam int P  = PRECISION;
    localparam int PW = 2 * P;
    localparam int SW = 2 * P + 1;

    typedef logic signed [P-1:0]  samp_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [SW-1:0] sum_t;

    localparam sum_t  SMAX = {{(P+2){1'b0}}, {(P-1){1'b1}}};
    localparam sum_t  SMIN = {{(P+2){1'b1}}, {(P-1){1'b0}}};
    localparam samp_t WONE = samp_t'(1 << FRAC);

    samp_t wgt  [N_CH];
    samp_t bias [N_CH];

    logic       s1_valid;
    logic [1:0] s1_mode;
    samp_t      s1_x [N_CH];

    logic       s2_valid;
    logic [1:0] s2_mode;
    samp_t      s2_x [N_CH];
    prod_t      s2_p [N_CH];

    logic                s3_valid;
    logic [N_CH*P-1:0]   s3_data;
    logic [N_CH-1:0]     s3_sat;

    prod_t           prod_c [N_CH];
    samp_t           res_c  [N_CH];
    logic [N_CH-1:0] sat_c;

    logic  adv;
    prod_t sh;
    sum_t  sum;
    samp_t pre;
    logic  psat;

    // Whole pipeline moves as one; S3 empty or draining lets it move.
    assign adv          = !s3_valid || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = s3_valid;
    assign io.out_data  = s3_data;
    assign io.out_sat   = s3_sat;
    assign cfg_ready    = !(s1_valid || s2_valid ||
                            s3_valid || io.in_valid);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            prod_c[i] = {{P{s1_x[i][P-1]}}, s1_x[i]} *
                        {{P{wgt[i][P-1]}}, wgt[i]};
        end
    end

    always_comb begin
        sh    = '0;
        sum   = '0;
        pre   = '0;
        psat  = 1'b0;
        sat_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            sh   = s2_p[i] >>> FRAC;
            sum  = {sh[PW-1], sh} +
                   {{(P+1){bias[i][P-1]}}, bias[i]};
            pre  = s2_x[i];
            psat = 1'b0;
            if (s2_mode[0]) begin
                unique case (1'b1)
                    (sum > SMAX): begin
                        pre  = SMAX[P-1:0];
                        psat = 1'b1;
                    end
                    (sum < SMIN): begin
                        pre  = SMIN[P-1:0];
                        psat = 1'b1;
                    end
                    default: pre = sum[P-1:0];
                endcase
            end
            // ReLU follows the clamp so a saturated flag survives it.
            res_c[i] = (s2_mode[1] && pre[P-1]) ? '0 : pre;
            sat_c[i] = psat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= '0;
            s2_valid <= 1'b0;
            s2_mode  <= '0;
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_sat   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                s1_x[i] <= '0;
                s2_x[i] <= '0;
                s2_p[i] <= '0;
            end
        end else if (adv) begin
            s1_valid <= io.in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            if (io.in_valid) begin
                s1_mode <= mode;
                for (int i = 0; i < N_CH; i++) begin
                    s1_x[i] <= io.in_data[i*P +: P];
                end
            end
            if (s1_valid) begin
                s2_mode <= s1_mode;
                for (int i = 0; i < N_CH; i++) begin
                    s2_x[i] <= s1_x[i];
                    s2_p[i] <= prod_c[i];
                end
            end
            if (s2_valid) begin
                s3_sat <= sat_c;
                for (int i = 0; i < N_CH; i++) begin
                    s3_data[i*P +: P] <= res_c[i];
                end
            end
        end
    end

    // Writes land only while nothing is in flight, so stages can
    // read weight/bias directly without carrying them along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                wgt[i]  <= WONE;
                bias[i] <= '0;
            end
        end else if (cfg_we && cfg_ready) begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_addr == CFG_AW'(i)) begin
                    if (cfg_sel) bias[i] <= cfg_wdata;
                    else         wgt[i]  <= cfg_wdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_photonic_stream_layer.sv
// Bench for photonic_stream_layer: constant vector table, directed
// stall/config/reset sequences and random traffic against a model.
module tb_photonic_stream_layer;
    localparam int N_CH      = 4;
    localparam int PRECISION = 8;
    localparam int FRAC      = 4;
    localparam int CFG_AW    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic              cfg_we;
    logic              cfg_sel;
    logic [CFG_AW-1:0] cfg_addr;
    logic [7:0]        cfg_wdata;
    logic              cfg_ready;

    photonic_stream_layer_if #(
        .N_CH(N_CH), .PRECISION(PRECISION)
    ) io ();

    photonic_stream_layer #(
        .N_CH(N_CH), .PRECISION(PRECISION),
        .FRAC(FRAC), .CFG_AW(CFG_AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(io),
        .mode(mode),
        .cfg_we(cfg_we),
        .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_ready(cfg_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  sat;
        logic [31:0] d;
    } res_t;

    typedef struct packed {
        logic [1:0]  md;
        logic [31:0] x;
        logic [31:0] e;
        logic [3:0]  sat;
    } vec_t;

    int   vecs = 0;
    int   errs = 0;
    int   ndel = 0;
    int   mw [4];
    int   mb [4];
    res_t expq [$];
    bit   stall_prev = 1'b0;
    logic [31:0] hold_d;
    logic [3:0]  hold_s;
    vec_t tv [10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b,
                                       input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic vec_t mk(input logic [1:0] md,
                                input logic [31:0] x,
                                input logic [31:0] e,
                                input logic [3:0] sat);
        vec_t v;
        v.md = md; v.x = x; v.e = e; v.sat = sat;
        return v;
    endfunction

    // Reference: real-valued x*w/16 floored, plus bias, clamped.
    function automatic logic [8:0] ref_ch(input int x, input int w,
                                          input int b,
                                          input logic [1:0] md);
        int p, q, r;
        bit s;
        logic [31:0] rv;
        s = 1'b0;
        if (md == 2'b00) r = x;
        else if (md == 2'b10) r = (x < 0) ? 0 : x;
        else begin
            p = x * w;
            if (p >= 0) q = p / (1 << FRAC);
            else q = -((-p + (1 << FRAC) - 1) / (1 << FRAC));
            r = q + b;
            if (r > 127) begin r = 127; s = 1'b1; end
            else if (r < -128) begin r = -128; s = 1'b1; end
            if (md == 2'b11 && r < 0) r = 0;
        end
        rv = r;
        return {s, rv[7:0]};
    endfunction

    function automatic res_t ref_model(input logic [31:0] d,
                                       input logic [1:0] md);
        res_t o;
        logic signed [7:0] xb;
        logic [8:0] c;
        for (int ch = 0; ch < 4; ch++) begin
            xb = d[ch*8 +: 8];
            c = ref_ch(int'(xb), mw[ch], mb[ch], md);
            o.d[ch*8 +: 8] = c[7:0];
            o.sat[ch] = c[8];
        end
        return o;
    endfunction

    task automatic step(input bit iv, input logic [31:0] d,
                        input logic [1:0] md, input bit ordy,
                        input bit cwe, input bit csel,
                        input logic [CFG_AW-1:0] ca,
                        input logic [7:0] cd, output bit acc);
        bit exp_cr;
        logic signed [7:0] cv;
        @(negedge clk);
        io.in_valid = iv; io.in_data = d; mode = md;
        io.out_ready = ordy;
        cfg_we = cwe; cfg_sel = csel; cfg_addr = ca; cfg_wdata = cd;
        #1;
        exp_cr = (expq.size() == 0) && !iv;
        chk("cfg_ready", cfg_ready, exp_cr);
        chk("in_ready", io.in_ready, !io.out_valid || ordy);
        if (expq.size() == 0) chk("idle_valid", io.out_valid, 0);
        if (stall_prev) begin
            chk("stall_valid", io.out_valid, 1);
            chk("stall_data", io.out_data, hold_d);
            chk("stall_sat", io.out_sat, hold_s);
        end
        acc = iv && io.in_ready;
        if (io.out_valid && ordy && expq.size() > 0) begin
            res_t e;
            e = expq.pop_front();
            chk("stream_data", io.out_data, e.d);
            chk("stream_sat", io.out_sat, e.sat);
            ndel++;
        end
        if (acc) expq.push_back(ref_model(d, md));
        if (cwe && exp_cr && ca < N_CH) begin
            cv = cd;
            if (csel) mb[ca] = int'(cv);
            else      mw[ca] = int'(cv);
        end
        stall_prev = io.out_valid && !ordy;
        hold_d = io.out_data;
        hold_s = io.out_sat;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(0, '0, 2'b00, 1, 0, 0, '0, '0, a);
    endtask

    task automatic cfg(input bit sel, input int addr, input int val);
        bit a;
        logic [31:0] v;
        v = val;
        step(0, '0, 2'b00, 1, 1, sel, CFG_AW'(addr), v[7:0], a);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        io.in_valid = 1'b1; io.in_data = v.x; mode = v.md;
        io.out_ready = 1'b1; cfg_we = 1'b0;
        #1 chk($sformatf("vec%0d_in_ready", idx), io.in_ready, 1);
        @(negedge clk);
        io.in_valid = 1'b0;
        lat = 1;
        while (!io.out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("vec%0d_latency", idx), lat, 3);
        chk($sformatf("vec%0d_data", idx), io.out_data, v.e);
        chk($sformatf("vec%0d_sat", idx), io.out_sat, v.sat);
        @(negedge clk);
        chk($sformatf("vec%0d_one_cycle", idx), io.out_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit a;
        int idx;
        tv[0] = mk(2'b01, pk(5, -3, 127, -128),
                   pk(5, -3, 127, -128), 4'b0000);
        tv[1] = mk(2'b01, pk(0, 20, 0, 0), pk(-20, 50, 0, 0), 4'b0000);
        tv[2] = mk(2'b01, pk(0, 60, 3, -3), pk(-20, 127, 4, 3), 4'b0010);
        tv[3] = mk(2'b11, pk(5, 0, -3, 5), pk(0, 10, 0, 0), 4'b0000);
        tv[4] = mk(2'b10, pk(-7, -1, 3, -128), pk(0, 0, 3, 0), 4'b0000);
        tv[5] = mk(2'b10, pk(9, 0, 0, 127), pk(9, 0, 0, 127), 4'b0000);
        tv[6] = mk(2'b00, pk(-100, 60, 7, -128),
                   pk(-100, 60, 7, -128), 4'b0000);
        tv[7] = mk(2'b01, pk(-128, -100, 127, -128),
                   pk(-128, -128, 127, 127), 4'b1111);
        tv[8] = mk(2'b11, pk(-128, -100, 127, -128),
                   pk(0, 0, 127, 127), 4'b1111);
        tv[9] = mk(2'b01, pk(1, -1, -1, 1), pk(-19, 8, -2, -1), 4'b0000);

        rst_n = 1'b0;
        io.in_valid = 1'b0; io.in_data = '0; io.out_ready = 1'b1;
        mode = 2'b00; cfg_we = 1'b0; cfg_sel = 1'b0;
        cfg_addr = '0; cfg_wdata = '0;
        for (int i = 0; i < 4; i++) begin mw[i] = 16; mb[i] = 0; end
        repeat (2) @(negedge clk);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_out_data", io.out_data, 0);
        chk("rst_out_sat", io.out_sat, 0);
        chk("rst_in_ready", io.in_ready, 1);
        chk("rst_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;

        run_vec(tv[0], 0);

        cfg(1, 0, -20);
        cfg(0, 1, 32);
        cfg(1, 1, 10);
        cfg(0, 2, 24);
        cfg(0, 3, -16);
        for (int i = 1; i < 10; i++) run_vec(tv[i], i);

        // Back-to-back stream with a three-cycle downstream stall.
        ndel = 0;
        idx = 0;
        for (int c = 0; c < 60 && (idx < 8 || expq.size() > 0); c++) begin
            step(idx < 8, pk(idx + 1, -(idx + 1), 10 * (idx + 1), idx - 3),
                 2'b01, !(c >= 4 && c <= 6), 0, 0, '0, '0, a);
            if (a) idx++;
        end
        chk("stall_accepted", idx, 8);
        chk("stall_delivered", ndel, 8);

        // Writes attempted while busy, alongside a sample, or out of range.
        step(1, pk(3, 3, 3, 3), 2'b01, 1, 0, 0, '0, '0, a);
        step(0, '0, 2'b00, 1, 1, 0, CFG_AW'(1), 8'd99, a);
        idle(4);
        step(1, pk(0, 20, 0, 0), 2'b01, 1, 1, 1, CFG_AW'(1), 8'hCE, a);
        idle(4);
        step(1, pk(0, 20, 0, 0), 2'b01, 1, 0, 0, '0, '0, a);
        idle(4);
        cfg(0, 4, 77);
        cfg(1, 7, 50);
        step(1, pk(7, 20, 9, -9), 2'b01, 1, 0, 0, '0, '0, a);
        idle(4);

        // Random traffic, modes, backpressure and opportunistic writes.
        for (int i = 0; i < 4; i++) begin
            cfg(0, i, int'($urandom_range(0, 255)));
            cfg(1, i, int'($urandom_range(0, 255)));
        end
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 4) != 0, $urandom, 2'($urandom),
                 ($urandom % 3) != 0, ($urandom % 8) == 0,
                 1'($urandom), CFG_AW'($urandom), 8'($urandom), a);
        end
        idle(8);
        chk("random_drained", expq.size(), 0);

        // Reset with samples in flight, one already at the output.
        cfg(1, 2, 5);
        for (int i = 0; i < 3; i++)
            step(1, pk(i + 1, 2, 3, 4), 2'b01, 1, 0, 0, '0, '0, a);
        @(negedge clk);
        io.in_valid = 1'b0;
        #1 chk("pre_reset_valid", io.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", io.out_valid, 0);
        chk("reset_out_data", io.out_data, 0);
        chk("reset_out_sat", io.out_sat, 0);
        expq.delete();
        stall_prev = 1'b0;
        for (int i = 0; i < 4; i++) begin mw[i] = 16; mb[i] = 0; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        step(1, pk(20, 60, -3, 7), 2'b01, 1, 0, 0, '0, '0, a);
        idle(5);
        chk("post_reset_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
